// File: rtl/memory_responder.sv
// memory_responder: word-addressed RAM answering the fetch and data ports.
// Ports: i_clk, i_reset_n; ins req/resp; data req/resp; optional error flags.
// Optional: `define MEMORY_RESPONDER_MISALIGN_ERR_EN adds o_*_resp_error.
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    output logic        o_ins_resp_error,
    output logic        o_data_resp_error,
`endif
    input  logic        i_ins_req_valid,
    output logic        o_ins_req_ready,
    input  logic [31:0] i_ins_address,
    output logic        o_ins_resp_valid,
    output logic [31:0] o_ins_data,
    input  logic        i_data_req_valid,
    output logic        o_data_req_ready,
    input  logic [31:0] i_data_address,
    input  logic        i_data_write_enable,
    input  logic [3:0]  i_data_write_strobe,
    input  logic [31:0] i_data_in,
    output logic        o_data_resp_valid,
    output logic [31:0] o_data_out
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int WAIT_LAST_I = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LAST_I);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic            own_data_q;
    logic            we_q;
    logic            mis_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     ins_data_q;
    logic [31:0]     data_out_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept_ins;
    logic            accept_data;
    logic            accept;
    logic [AW-1:0]   acc_idx;
    logic            acc_we;
    logic            acc_mis;
    logic            enter_resp;
    logic [AW-1:0]   rd_idx;
    logic            rd_own;
    logic            rd_we;
    logic            rd_mis;
    logic            unused_addr;

    assign accept  = accept_ins | accept_data;
    assign acc_idx = accept_data ? i_data_address[AW+1:2]
                                 : i_ins_address[AW+1:2];
    assign acc_we  = accept_data & i_data_write_enable;

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    assign acc_mis = accept_data ? (|i_data_address[1:0])
                                 : (|i_ins_address[1:0]);
    assign unused_addr = ^{i_ins_address[31:AW+2],
                           i_data_address[31:AW+2]};
`else
    assign acc_mis = 1'b0;
    assign unused_addr = ^{i_ins_address[31:AW+2], i_ins_address[1:0],
                           i_data_address[31:AW+2], i_data_address[1:0]};
`endif

    // With LATENCY=1 the read happens on the accept edge itself,
    // before the request fields have been latched.
    assign enter_resp = (state_d == RESPOND) && (state_q != RESPOND);
    assign rd_idx = (state_q == IDLE) ? acc_idx : idx_q;
    assign rd_own = (state_q == IDLE) ? accept_data : own_data_q;
    assign rd_we  = (state_q == IDLE) ? acc_we : we_q;
    assign rd_mis = (state_q == IDLE) ? acc_mis : mis_q;

    always_comb begin
        state_d     = state_q;
        accept_ins  = 1'b0;
        accept_data = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_data_req_valid) begin
                    accept_data = i_reset_n;
                end else if (i_ins_req_valid) begin
                    accept_ins = i_reset_n;
                end
                if (accept_ins || accept_data) begin
                    state_d = (LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            idx_q      <= '0;
            ins_data_q <= '0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= '0;
                own_data_q <= accept_data;
                we_q       <= acc_we;
                mis_q      <= acc_mis;
                idx_q      <= acc_idx;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (enter_resp) begin
                if (rd_own) begin
                    data_out_q <= (rd_we || rd_mis) ? 32'h0 : mem[rd_idx];
                end else begin
                    ins_data_q <= rd_mis ? 32'h0 : mem[rd_idx];
                end
            end
        end
    end

    // Backing store is not reset; writes commit on the accept edge.
    always_ff @(posedge i_clk) begin
        if (acc_we && !acc_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (i_data_write_strobe[b]) begin
                    mem[acc_idx][8*b +: 8] <= i_data_in[8*b +: 8];
                end
            end
        end
    end

    assign o_data_req_ready = (state_q == IDLE) && i_reset_n;
    assign o_ins_req_ready  = (state_q == IDLE) && i_reset_n
                              && !i_data_req_valid;
    assign o_ins_resp_valid  = (state_q == RESPOND) && !own_data_q;
    assign o_data_resp_valid = (state_q == RESPOND) && own_data_q;
    assign o_ins_data = ins_data_q;
    assign o_data_out = data_out_q;

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    assign o_ins_resp_error  = o_ins_resp_valid && mis_q;
    assign o_data_resp_error = o_data_resp_valid && mis_q;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench for two memory_responder builds.
// u0: defaults (1024 words, latency 1); u1: 16 words, latency 3.
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv [2];
    logic        dv [2];
    logic        ir [2];
    logic        dr [2];
    logic        irv [2];
    logic        drv [2];
    logic        ie [2];
    logic        de [2];
    logic [31:0] idat [2];
    logic [31:0] dout [2];
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] din;
    logic        we;
    logic [3:0]  st;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    memory_responder u0 (
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        .o_ins_resp_error(ie[0]),
        .o_data_resp_error(de[0]),
`endif
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_ins_req_valid(iv[0]),
        .o_ins_req_ready(ir[0]),
        .i_ins_address(ia),
        .o_ins_resp_valid(irv[0]),
        .o_ins_data(idat[0]),
        .i_data_req_valid(dv[0]),
        .o_data_req_ready(dr[0]),
        .i_data_address(da),
        .i_data_write_enable(we),
        .i_data_write_strobe(st),
        .i_data_in(din),
        .o_data_resp_valid(drv[0]),
        .o_data_out(dout[0])
    );

    memory_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u1 (
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        .o_ins_resp_error(ie[1]),
        .o_data_resp_error(de[1]),
`endif
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_ins_req_valid(iv[1]),
        .o_ins_req_ready(ir[1]),
        .i_ins_address(ia),
        .o_ins_resp_valid(irv[1]),
        .o_ins_data(idat[1]),
        .i_data_req_valid(dv[1]),
        .o_data_req_ready(dr[1]),
        .i_data_address(da),
        .i_data_write_enable(we),
        .i_data_write_strobe(st),
        .i_data_in(din),
        .o_data_resp_valid(drv[1]),
        .o_data_out(dout[1])
    );

`ifndef MEMORY_RESPONDER_MISALIGN_ERR_EN
    assign ie[0] = 1'b0;
    assign ie[1] = 1'b0;
    assign de[0] = 1'b0;
    assign de[1] = 1'b0;
`endif

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int s, bit isd, logic [31:0] d, logic e);
        exp_t x;
        x.is_data = isd;
        x.data = d;
        x.err = e;
        if (s == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (irv[s] || drv[s]) begin
                exp_t e;
                bit   empty;
                empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
                check("sb_nonempty", 32'(empty), 32'h0);
                if (!empty) begin
                    if (s == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    check("resp_port", 32'(drv[s]), 32'(e.is_data));
                    check("resp_excl", 32'(irv[s] & drv[s]), 32'h0);
                    check("resp_rdy", 32'(ir[s] | dr[s]), 32'h0);
                    check("resp_data", e.is_data ? dout[s] : idat[s],
                          e.data);
                    check("resp_err", 32'(e.is_data ? de[s] : ie[s]),
                          32'(e.err));
                end
            end
        end
    end

    task automatic do_req(int s, bit isd, logic [31:0] a, bit w,
                          logic [3:0] strb, logic [31:0] wd,
                          logic [31:0] ed, logic ee, int lat);
        int n;
        bit got;
        @(negedge clk);
        check("idle_rdy", {30'h0, ir[s], dr[s]}, 32'h3);
        push(s, isd, ed, ee);
        if (isd) begin
            dv[s] = 1'b1;
            da = a;
            we = w;
            st = strb;
            din = wd;
        end else begin
            iv[s] = 1'b1;
            ia = a;
        end
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        dv[s] = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            got = irv[s] | drv[s];
            if (!got) check("busy_rdy", {30'h0, ir[s], dr[s]}, 32'h0);
        end
        check("latency", 32'(n), 32'(lat));
    endtask

    initial begin
        iv[0] = 0; iv[1] = 0; dv[0] = 0; dv[1] = 0;
        ia = 0; da = 0; din = 0; we = 0; st = 0;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ctl", {26'h0, ir[s], dr[s], irv[s], drv[s],
                              ie[s], de[s]}, 32'h0);
            check("rst_idat", idat[s], 32'h0);
            check("rst_dout", dout[s], 32'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_rdy0", {30'h0, ir[0], dr[0]}, 32'h3);
        check("rel_rdy1", {30'h0, ir[1], dr[1]}, 32'h3);

        do_req(0, 1, 32'h10, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1);
        do_req(0, 1, 32'h10, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1);
        @(negedge clk);
        check("hold_dout", dout[0], 32'hDEADBEEF);
        do_req(0, 0, 32'h10, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1);
        do_req(0, 1, 32'h10, 1, 4'h5, 32'h11223344, 32'h0, 0, 1);
        do_req(0, 1, 32'h10, 0, 4'h0, 32'h0, 32'hDE22BE44, 0, 1);
        do_req(0, 1, 32'h0, 1, 4'hF, 32'hA0A0A0A0, 32'h0, 0, 1);
        do_req(0, 1, 32'h4, 1, 4'hF, 32'h44444444, 32'h0, 0, 1);
        do_req(0, 1, 32'h4, 1, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 1);
        do_req(0, 1, 32'h4, 0, 4'h0, 32'h0, 32'h44444444, 0, 1);
        do_req(0, 0, 32'h1010, 0, 4'h0, 32'h0, 32'hDE22BE44, 0, 1);

        @(negedge clk);
        push(0, 1, 32'h44444444, 0);
        push(0, 0, 32'hA0A0A0A0, 0);
        dv[0] = 1'b1; da = 32'h4; we = 1'b0; st = 4'h0;
        iv[0] = 1'b1; ia = 32'h0;
        #1;
        check("arb_drdy", 32'(dr[0]), 32'h1);
        check("arb_irdy", 32'(ir[0]), 32'h0);
        @(posedge clk);
        #1 dv[0] = 1'b0;
        @(negedge clk);
        check("arb_dresp", 32'(drv[0]), 32'h1);
        check("arb_irdy_busy", 32'(ir[0]), 32'h0);
        @(negedge clk);
        check("arb_irdy_later", 32'(ir[0]), 32'h1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);
        check("arb_iresp", 32'(irv[0]), 32'h1);

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        do_req(0, 1, 32'h13, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, 1);
        do_req(0, 1, 32'h10, 0, 4'h0, 32'h0, 32'hDE22BE44, 0, 1);
        do_req(0, 0, 32'h2, 0, 4'h0, 32'h0, 32'h0, 1, 1);
        do_req(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'hA0A0A0A0, 0, 1);
`endif

        do_req(1, 1, 32'h40, 1, 4'hF, 32'h12345678, 32'h0, 0, 3);
        do_req(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h12345678, 0, 3);

        @(negedge clk);
        dv[1] = 1'b1; da = 32'h24; we = 1'b1; st = 4'hF;
        din = 32'hCAFEF00D;
        @(posedge clk);
        #1 dv[1] = 1'b0;
        @(negedge clk);
        check("mid_busy", {30'h0, ir[1], dr[1]}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out", {30'h0, irv[1], drv[1]}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_resp", {30'h0, irv[1], drv[1]}, 32'h0);
            check("mid_idle", {30'h0, ir[1], dr[1]}, 32'h3);
        end
        do_req(1, 1, 32'h24, 0, 4'h0, 32'h0, 32'hCAFEF00D, 0, 3);

        repeat (3) @(negedge clk);
        check("sb_drain0", 32'(q0.size()), 32'h0);
        check("sb_drain1", 32'(q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
